// File: rtl/prio_encoder_pkg.sv
// Shared helpers for the registered priority encoder: width calculation,
// active-low code inversion and the idle code.
package prio_encoder_pkg;

    localparam int unsigned CODE_MAX_W = 32;

    // All-ones code driven on dout when no grant is valid
    localparam logic [CODE_MAX_W-1:0] IDLE_CODE = '1;

    // ceil(log2(n)) but never below 1, so a 2-channel encoder still has a code bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((33'd1 << i) < 33'(n)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Channel index to active-low code
    function automatic logic [CODE_MAX_W-1:0] inv_code(input logic [CODE_MAX_W-1:0] idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder: highest set bit of the pending vector.
module prio_enc_comb
    import prio_encoder_pkg::*;
#(
    parameter  int unsigned N = 8,
    localparam int unsigned W = clog2_min1(N)
) (
    input  logic [N-1:0] pend,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan upward so the highest pending index is the last one written
    always_comb begin
        idx = '0;
        any = |pend;
        for (int unsigned i = 0; i < N; i++) begin
            if (pend[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_encoder_irq.sv
// Registered N-channel active-low priority encoder with pending capture and
// one-cycle ack retirement; ex_out/s_out keep 74148 cascade semantics.
// Define PRIO_ENCODER_IRQ_EDGE_EN to capture requests on falling edges of din
// instead of on level.
module prio_encoder_irq
    import prio_encoder_pkg::*;
#(
    parameter  int unsigned N = 8,
    localparam int unsigned W = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         select,
    input  logic         ack,
    output logic [W-1:0] dout,
    output logic         ex_out,
    output logic         s_out
);

    logic [N-1:0] pend;
    logic [N-1:0] pend_next;
    logic [N-1:0] set_mask;
    logic [N-1:0] clr_mask;
    logic [W-1:0] shown;
    logic [W-1:0] idx;
    logic         any;
    logic         ack_ok;

    // Ack retires the channel currently presented; only meaningful while enabled
    assign shown    = ~dout;
    assign ack_ok   = ack && !ex_out && !select;
    assign clr_mask = ack_ok ? (N'(1) << shown) : '0;

`ifdef PRIO_ENCODER_IRQ_EDGE_EN
    logic [N-1:0] hist;

    // Previous din sample for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '1;
        end else begin
            hist <= din;
        end
    end

    assign set_mask = hist & ~din;
`else
    assign set_mask = ~din;
`endif

    // Set beats clear when a channel is requested and retired in the same cycle
    assign pend_next = (pend & ~clr_mask) | set_mask;

    prio_enc_comb #(.N(N)) u_enc (
        .pend (pend_next),
        .idx  (idx),
        .any  (any)
    );

    // Pending state and outputs, both derived from pend_next
    always_ff @(posedge clk) begin
        if (rst) begin
            pend   <= '0;
            dout   <= W'(IDLE_CODE);
            ex_out <= 1'b1;
            s_out  <= 1'b1;
        end else begin
            pend <= pend_next;
            if (select) begin
                dout   <= W'(IDLE_CODE);
                ex_out <= 1'b1;
                s_out  <= 1'b1;
            end else if (any) begin
                dout   <= W'(inv_code(CODE_MAX_W'(idx)));
                ex_out <= 1'b0;
                s_out  <= 1'b1;
            end else begin
                dout   <= W'(IDLE_CODE);
                ex_out <= 1'b1;
                s_out  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_irq.sv
// Scoreboard bench for prio_encoder_irq (N=8). Expected {dout, ex_out, s_out}
// is queued as each cycle's stimulus is driven and popped after the edge.
module tb_prio_encoder_irq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       select;
    logic       ack;
    logic [2:0] dout;
    logic       ex_out;
    logic       s_out;

    int errors = 0;
    int checks = 0;

    logic [4:0] sb [$];

`ifdef PRIO_ENCODER_IRQ_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    // Expected encodings {dout, ex_out, s_out}
    localparam logic [4:0] OFF  = 5'b111_1_1;
    localparam logic [4:0] IDLE = 5'b111_1_0;

    typedef struct packed {
        logic       rst;
        logic [7:0] din;
        logic       sel;
        logic       ack;
        logic [4:0] exp;
    } step_t;

    function automatic logic [4:0] grant(input int ch);
        logic [2:0] c;
        c = 3'(ch);
        return {~c, 1'b0, 1'b1};
    endfunction

    prio_encoder_irq #(.N(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .select (select),
        .ack    (ack),
        .dout   (dout),
        .ex_out (ex_out),
        .s_out  (s_out)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        step_t st [3];
        logic [4:0] got, exp;
        st = '{'{1'b1, 8'hFF, 1'b0, 1'b0, OFF},
               '{1'b0, 8'hFF, 1'b0, 1'b0, IDLE},
               '{1'b0, 8'hFF, 1'b0, 1'b0, IDLE}};
        foreach (st[k]) begin
            rst = st[k].rst; din = st[k].din; select = st[k].sel; ack = st[k].ack;
            sb.push_back(st[k].exp);
            @(posedge clk); #1;
            got = {dout, ex_out, s_out};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset step %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_single();
        step_t st [5];
        logic [4:0] got, exp;
        st = '{'{1'b0, 8'hFE, 1'b0, 1'b0, grant(0)},
               '{1'b0, 8'hFF, 1'b0, 1'b0, grant(0)},
               '{1'b0, 8'hFF, 1'b0, 1'b0, grant(0)},
               '{1'b0, 8'hFF, 1'b0, 1'b1, IDLE},
               '{1'b0, 8'hFF, 1'b0, 1'b0, IDLE}};
        foreach (st[k]) begin
            rst = st[k].rst; din = st[k].din; select = st[k].sel; ack = st[k].ack;
            sb.push_back(st[k].exp);
            @(posedge clk); #1;
            got = {dout, ex_out, s_out};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single_ch0 step %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t st [5];
        logic [4:0] got, exp;
        st = '{'{1'b0, 8'b1101_1011, 1'b0, 1'b0, grant(5)},
               '{1'b0, 8'hFF,        1'b0, 1'b0, grant(5)},
               '{1'b0, 8'hFF,        1'b0, 1'b1, grant(2)},
               '{1'b0, 8'hFF,        1'b0, 1'b1, IDLE},
               '{1'b0, 8'hFF,        1'b0, 1'b0, IDLE}};
        foreach (st[k]) begin
            rst = st[k].rst; din = st[k].din; select = st[k].sel; ack = st[k].ack;
            sb.push_back(st[k].exp);
            @(posedge clk); #1;
            got = {dout, ex_out, s_out};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back step %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_preempt();
        step_t st [9];
        logic [4:0] got, exp;
        st = '{'{1'b0, 8'hFD, 1'b0, 1'b0, grant(1)},
               '{1'b0, 8'hFF, 1'b0, 1'b0, grant(1)},
               '{1'b0, 8'h7F, 1'b0, 1'b0, grant(7)},
               '{1'b0, 8'hFF, 1'b0, 1'b1, grant(1)},
               '{1'b0, 8'hFF, 1'b0, 1'b1, IDLE},
               // ack in the preempting cycle retires ch1, not ch7
               '{1'b0, 8'hFD, 1'b0, 1'b0, grant(1)},
               '{1'b0, 8'h7F, 1'b0, 1'b1, grant(7)},
               '{1'b0, 8'hFF, 1'b0, 1'b1, IDLE},
               '{1'b0, 8'hFF, 1'b0, 1'b0, IDLE}};
        foreach (st[k]) begin
            rst = st[k].rst; din = st[k].din; select = st[k].sel; ack = st[k].ack;
            sb.push_back(st[k].exp);
            @(posedge clk); #1;
            got = {dout, ex_out, s_out};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL preempt step %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_select();
        step_t st [6];
        logic [4:0] got, exp;
        st = '{'{1'b0, 8'hF7, 1'b0, 1'b0, grant(3)},
               '{1'b0, 8'hFF, 1'b1, 1'b0, OFF},
               '{1'b0, 8'hFF, 1'b1, 1'b1, OFF},
               '{1'b0, 8'hFF, 1'b0, 1'b0, grant(3)},
               '{1'b0, 8'hFF, 1'b0, 1'b1, IDLE},
               '{1'b0, 8'hFF, 1'b0, 1'b0, IDLE}};
        foreach (st[k]) begin
            rst = st[k].rst; din = st[k].din; select = st[k].sel; ack = st[k].ack;
            sb.push_back(st[k].exp);
            @(posedge clk); #1;
            got = {dout, ex_out, s_out};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL select step %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_hold();
        step_t st [16];
        logic [4:0] got, exp;
        logic [4:0] after_ack;
        after_ack = EDGE ? IDLE : grant(4);
        for (int k = 0; k < 10; k++) begin
            st[k] = '{1'b0, 8'hEF, 1'b0, (k == 2), (k < 2) ? grant(4) : after_ack};
        end
        st[10] = '{1'b0, 8'hFF, 1'b0, 1'b0, after_ack};
        st[11] = '{1'b0, 8'hEF, 1'b0, 1'b0, grant(4)};
        st[12] = '{1'b0, 8'hFF, 1'b0, 1'b0, grant(4)};
        // new request and ack of the same channel in one cycle: set wins
        st[13] = '{1'b0, 8'hEF, 1'b0, 1'b1, grant(4)};
        st[14] = '{1'b0, 8'hFF, 1'b0, 1'b1, IDLE};
        st[15] = '{1'b0, 8'hFF, 1'b0, 1'b0, IDLE};
        foreach (st[k]) begin
            rst = st[k].rst; din = st[k].din; select = st[k].sel; ack = st[k].ack;
            sb.push_back(st[k].exp);
            @(posedge clk); #1;
            got = {dout, ex_out, s_out};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL hold_ch4 step %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        step_t st [5];
        logic [4:0] got, exp;
        st = '{'{1'b0, 8'hBF, 1'b0, 1'b0, grant(6)},
               '{1'b1, 8'hFF, 1'b0, 1'b1, OFF},
               '{1'b0, 8'hFF, 1'b0, 1'b0, IDLE},
               '{1'b1, 8'hBF, 1'b0, 1'b0, OFF},
               '{1'b0, 8'hFF, 1'b0, 1'b0, IDLE}};
        foreach (st[k]) begin
            rst = st[k].rst; din = st[k].din; select = st[k].sel; ack = st[k].ack;
            sb.push_back(st[k].exp);
            @(posedge clk); #1;
            got = {dout, ex_out, s_out};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_reset step %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; din = 8'hFF; select = 1'b0; ack = 1'b0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_preempt();
        test_select();
        test_hold();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_encoder_irq.md
# prio_encoder_irq

Parametrised, registered successor to the 8-to-3 active-low priority encoder. It captures N active-low request lines into a pending register and presents the highest-priority pending channel as an active-low code. The consumer acknowledges with a one-cycle `ack` handshake, which retires that channel; the cascade outputs `ex_out` and `s_out` keep their 74148-style meaning. It sits between raw request/interrupt lines and a sequential consumer (FSM or CPU-side logic) that services one channel at a time.

## Interface
- `N`, 8: number of request channels; legal range N ≥ 2.
- `W`, $clog2(N): code width; derived, not to be overridden.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `din`  in  N  request lines, active-low; `din[N-1]` has highest priority.
- `select`  in  1  chip enable, active-low.
- `ack`  in  1  active-high; retires the channel currently shown on `dout`.
- `dout`  out  W  active-low code of the granted channel (index i → ~i).
- `ex_out`  out  1  active-low; a grant is valid on `dout`.
- `s_out`  out  1  active-low; enabled and nothing pending (cascade strobe).

## Operation
- Internal state: `pend[N-1:0]` (1 = channel pending). All outputs are registered.
- Set rule, macro absent: `pend[i]` is set every cycle `din[i]==0` (level, sticky).
- Clear rule: the ack is accepted when `ack==1 && ex_out==0 && select==0`. An accepted ack clears `pend[~dout]`. If `din` is still low on that channel in the same cycle, set wins and the channel stays pending.
- `pend_next = (pend & ~clr_mask) | set_mask`.
- Output registers are computed from `pend_next`, never from stale `pend`, so a retired channel is never re-issued.
- With `select==0` and `pend_next != 0`: `dout` = ~(highest set index), `ex_out=0`, `s_out=1`.
- With `select==0` and `pend_next == 0`: `dout` = all ones, `ex_out=1`, `s_out=0`.
- With `select==1`: `dout` = all ones, `ex_out=1`, `s_out=1`. Capture into `pend` continues. `ack` is ignored.
- If N is not a power of two, codes for indices ≥ N are never produced.

## Timing
- Reset values: `pend`=0, `dout`=all ones, `ex_out`=1, `s_out`=1 (first cycle after reset, regardless of `select`).
- Edge-detect history register, if compiled in, resets to all ones.
- Latency: `din[i]` low sampled at edge k → `dout`/`ex_out` reflect it after edge k.
- Ack handshake: an ack accepted at edge k → next-priority channel (or idle) is shown after edge k. Back-to-back acks on consecutive cycles retire one channel per cycle.
- A higher-priority request arriving while a lower one is shown preempts it at the next edge. The lower channel stays pending. An ack in that same cycle retires the channel shown before the edge.
- `rst` asserted mid-operation discards all pending channels at that edge. `rst` has priority over everything.

## Configuration
- `PRIO_ENCODER_IRQ_EDGE_EN` defined: `pend[i]` is set only on a 1→0 transition of `din[i]`, using an N-bit registered history of `din`. A line held low is captured once. After it is acked it stays retired until it goes high and falls again. On simultaneous new edge and ack of the same channel, set wins.
- `PRIO_ENCODER_IRQ_EDGE_EN` undefined: level capture as described under Operation. The history register is not built.

## Structure
- Package `prio_encoder_pkg`: function `clog2_min1`, the code-inversion helper function, and localparam `IDLE_CODE` (all ones).
- One combinational sub-module, `prio_enc_comb`, parametrised by N. Inputs: pending vector. Outputs: index (W bits) and `any`.
- Top level holds `pend`, the optional history register, ack qualification, and the output registers.

## Test plan
- Reset, then N=8, `select`=0, `din`=8'hFF → `dout`=3'b111, `ex_out`=1, `s_out`=0 after the first post-reset edge.
- `din`=8'b1111_1110 (ch0) for 1 cycle, then 8'hFF → `dout`=3'b111, `ex_out`=0 held until ack. Ack → `ex_out`=1, `s_out`=0 next cycle.
- Channels 2 and 5 pulsed low together → `dout`=~5=3'b010. Ack → `dout`=~2=3'b101. Ack → idle.
- Channel 1 shown; channel 7 pulsed low → next cycle `dout`=3'b000. Ack → `dout`=3'b110 (ch1 still pending).
- Channel 3 pending, `select`=1 → `dout`=3'b111, `ex_out`=1, `s_out`=1. Ack ignored. `select`=0 → `dout`=3'b100 again.
- Edge mode: `din[4]` held low for 10 cycles, acked at cycle 3 → idle after ack. Release, then fall again → re-pending. Level mode with the same stimulus → stays pending through the ack.
